multi_line_buffer: RTL and testbench

MULTI_LINE_BUFFER -- requirements
Module: multi_line_buffer

---
 rtl/multi_line_buffer.sv | 116 +++++++++++
 tb/tb_multi_line_buffer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_line_buffer.sv
// Cascaded circular line delays with registered column taps for 2-D window filters.
// Optional end-of-line flag output eol_o is enabled by defining LINE_BUF_EOL_EN.
module multi_line_buffer #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 640,
   parameter int LINES  = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        we_i,
   input  logic [DATA_W-1:0]           data_i,
   input  logic                        flush_i,
   output logic [(LINES+1)*DATA_W-1:0] data_o,
   output logic                        valid_o,
   output logic                        done_o,
`ifdef LINE_BUF_EOL_EN
   output logic                        eol_o,
`endif
   output logic [$clog2(DEPTH)-1:0]    col_o
);

   localparam int AW    = $clog2(DEPTH);
   localparam int PRIME = LINES * DEPTH;
   localparam int CW    = $clog2(PRIME + 1);

   localparam logic [AW-1:0] LAST_COL  = AW'(DEPTH - 1);
   localparam logic [CW-1:0] PRIME_CNT = CW'(PRIME);

   logic [AW-1:0]                  ptr_q;
   logic [CW-1:0]                  count_q;
   logic                           wr_en;
   logic                           primed;
   logic [LINES-1:0][DATA_W-1:0]   rd_data;

   // A flush cycle discards the incoming sample entirely.
   assign wr_en = we_i & ~flush_i;

   // Primed once every line already holds a full line of samples, so the
   // deepest tap of the current write is a genuine sample.
   assign primed = (count_q == PRIME_CNT);

   for (genvar k = 0; k < LINES; k++) begin : g_line
      logic [DATA_W-1:0] mem [DEPTH];
      logic [DATA_W-1:0] wdata;

      if (k == 0) begin : g_head
         assign wdata = data_i;
      end else begin : g_tail
         assign wdata = rd_data[k-1];
      end

      // Asynchronous read gives read-before-write at the shared pointer.
      assign rd_data[k] = mem[ptr_q];

      // NOTE: storage arrays carry no reset so they map onto RAM primitives;
      // stale contents are harmless because outputs require re-priming.
      always_ff @(posedge clk) begin
         if (wr_en) begin
            mem[ptr_q] <= wdata;
         end
      end
   end

   // NOTE: all sequential state is updated with non-blocking assignments so
   // every register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_o <= '0;
      end else if (wr_en) begin
         data_o[DATA_W-1:0] <= data_i;
         for (int k = 1; k <= LINES; k++) begin
            data_o[k*DATA_W +: DATA_W] <= rd_data[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q   <= '0;
         count_q <= '0;
         col_o   <= '0;
         valid_o <= 1'b0;
         done_o  <= 1'b0;
`ifdef LINE_BUF_EOL_EN
         eol_o   <= 1'b0;
`endif
      end else if (flush_i) begin
         ptr_q   <= '0;
         count_q <= '0;
         valid_o <= 1'b0;
         done_o  <= 1'b0;
`ifdef LINE_BUF_EOL_EN
         eol_o   <= 1'b0;
`endif
      end else if (we_i) begin
         ptr_q   <= (ptr_q == LAST_COL) ? '0 : ptr_q + AW'(1);
         col_o   <= ptr_q;
         valid_o <= primed;
         if (!primed) begin
            count_q <= count_q + CW'(1);
         end
         if (primed) begin
            done_o <= 1'b1;
         end
`ifdef LINE_BUF_EOL_EN
         eol_o   <= primed && (ptr_q == LAST_COL);
`endif
      end else begin
         valid_o <= 1'b0;
`ifdef LINE_BUF_EOL_EN
         eol_o   <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_multi_line_buffer.sv
// Directed bench for multi_line_buffer at DEPTH=5, LINES=2: priming, gaps, wrap,
// flush and asynchronous reset. Define LINE_BUF_EOL_EN to also check eol_o.
module tb_multi_line_buffer;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 5;
   localparam int LINES  = 2;

   typedef struct {
      logic       we;
      logic       flush;
      logic [7:0] data;
      logic       valid;
      logic       done;
      logic [2:0] col;
      logic       chk_col;
      logic [7:0] t0;
      logic [7:0] t1;
      logic [7:0] t2;
      logic [1:0] chk;     // 0: no taps, 1: tap 0 only, 2: all taps
   } vec_t;

   logic                        clk;
   logic                        rst;
   logic                        we_i;
   logic [DATA_W-1:0]           data_i;
   logic                        flush_i;
   logic [(LINES+1)*DATA_W-1:0] data_o;
   logic                        valid_o;
   logic                        done_o;
   logic [2:0]                  col_o;
`ifdef LINE_BUF_EOL_EN
   logic                        eol_o;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   vec_t vecs[$];

   multi_line_buffer #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .LINES (LINES)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .we_i   (we_i),
      .data_i (data_i),
      .flush_i(flush_i),
      .data_o (data_o),
      .valid_o(valid_o),
      .done_o (done_o),
`ifdef LINE_BUF_EOL_EN
      .eol_o  (eol_o),
`endif
      .col_o  (col_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input bit we, input bit flush, input int data,
                               input bit valid, input bit done, input int col,
                               input bit chk_col, input int t0, input int t1,
                               input int t2, input int chk);
      vec_t v;
      v.we      = we;
      v.flush   = flush;
      v.data    = 8'(data);
      v.valid   = valid;
      v.done    = done;
      v.col     = 3'(col);
      v.chk_col = chk_col;
      v.t0      = 8'(t0);
      v.t1      = 8'(t1);
      v.t2      = 8'(t2);
      v.chk     = 2'(chk);
      return v;
   endfunction

   // Drive on the falling edge, check just after the following rising edge.
   task automatic apply(input vec_t v, input string tag);
      @(negedge clk);
      we_i    = v.we;
      flush_i = v.flush;
      data_i  = v.data;
      @(posedge clk);
      #1;
      check({tag, " valid"}, 32'(valid_o), 32'(v.valid));
      check({tag, " done"},  32'(done_o),  32'(v.done));
      if (v.chk_col)
         check({tag, " col"}, 32'(col_o), 32'(v.col));
      if (v.chk != 2'd0)
         check({tag, " tap0"}, 32'(data_o[7:0]), 32'(v.t0));
      if (v.chk == 2'd2) begin
         check({tag, " tap1"}, 32'(data_o[15:8]),  32'(v.t1));
         check({tag, " tap2"}, 32'(data_o[23:16]), 32'(v.t2));
      end
`ifdef LINE_BUF_EOL_EN
      check({tag, " eol"}, 32'(eol_o), 32'(v.valid && v.col == 3'd4));
`endif
   endtask

   task automatic drive(input bit we, input bit flush, input int data);
      @(negedge clk);
      we_i    = we;
      flush_i = flush;
      data_i  = 8'(data);
      @(posedge clk);
      #1;
   endtask

   task automatic run_vecs(input string tag);
      for (int i = 0; i < vecs.size(); i++)
         apply(vecs[i], $sformatf("%s[%0d]", tag, i));
      vecs.delete();
   endtask

   initial begin
      rst     = 1'b1;
      we_i    = 1'b0;
      flush_i = 1'b0;
      data_i  = '0;

      // Power-on reset: outputs must clear without any clock edge.
      #1 rst = 1'b0;
      #2;
      check("por valid", 32'(valid_o), 32'd0);
      check("por done",  32'(done_o),  32'd0);
      check("por col",   32'(col_o),   32'd0);
      check("por data",  32'(data_o),  32'd0);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;

      // Priming and wrap: writes 1..15, first valid after 11 with (11,6,1).
      for (int v = 1; v <= 15; v++)
         vecs.push_back(mk(1, 0, v, v >= 11, v >= 11, (v - 1) % 5, 1,
                           v, v - 5, v - 10, (v >= 11) ? 2 : 1));
      run_vecs("prime");

      // Standalone flush clears flags.
      apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "flush0");

      // Gaps: same stream with idle cycles; taps hold, valid only after writes.
      for (int v = 1; v <= 15; v++) begin
         vecs.push_back(mk(1, 0, v, v >= 11, v >= 11, (v - 1) % 5, 1,
                           v, v - 5, v - 10, (v >= 11) ? 2 : 1));
         vecs.push_back(mk(0, 0, 8'hee, 0, v >= 11, (v - 1) % 5, 1,
                           v, v - 5, v - 10, (v >= 11) ? 2 : 1));
      end
      run_vecs("gap");

      // Flush with a simultaneous write after 12 writes.
      apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "flush1");
      for (int v = 1; v <= 12; v++)
         vecs.push_back(mk(1, 0, v, v >= 11, v >= 11, (v - 1) % 5, 1,
                           v, v - 5, v - 10, (v >= 11) ? 2 : 1));
      vecs.push_back(mk(1, 1, 50, 0, 0, 0, 0, 0, 0, 0, 0));
      // Dropped sample means the next write lands on column 0 again.
      for (int i = 0; i < 11; i++)
         vecs.push_back(mk(1, 0, 201 + i, i == 10, i == 10, i % 5, 1,
                           201 + i, 196 + i, 191 + i, (i == 10) ? 2 : 1));
      run_vecs("flushwr");

      // Asynchronous reset mid-frame, 13 writes into a primed state.
      for (int v = 1; v <= 13; v++)
         drive(1, 0, v);
      we_i = 1'b0;
      check("pre-rst done", 32'(done_o), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("rst valid", 32'(valid_o), 32'd0);
      check("rst done",  32'(done_o),  32'd0);
      check("rst col",   32'(col_o),   32'd0);
      check("rst data",  32'(data_o),  32'd0);
      @(posedge clk);
      #3 rst = 1'b1;

      // Re-priming after reset, first edge accepts a write.
      for (int v = 1; v <= 11; v++)
         vecs.push_back(mk(1, 0, v, v == 11, v == 11, (v - 1) % 5, 1,
                           v, v - 5, v - 10, (v == 11) ? 2 : 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 11, 6, 1, 2));
      run_vecs("postrst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
